// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state codes and helpers
// for the PWM table player and its comparator.
package pwm_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t PRIME0 = 2'd1;
  localparam state_t PRIME1 = 2'd2;
  localparam state_t RUN    = 2'd3;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic logic [31:0] sat(
    input logic [31:0] d,
    input logic [31:0] lim
  );
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/pwm_comparator.sv
// pwm_comparator: carrier counter, saturating
// duty compare and registered PWM output.
module pwm_comparator
  import pwm_pkg::*;
#(
  parameter int data_width = 8,
  parameter int pwm_period = 100
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  active_nx,
  input  logic                  load,
  input  logic [data_width-1:0] duty_nx,
  output logic                  wrap,
  output logic                  PWM_out
);

  localparam int CW = cw(pwm_period);
  localparam int SW = max2(data_width, cw(pwm_period + 1));
  localparam logic [CW-1:0] CMAX = CW'(pwm_period - 1);

  logic [CW-1:0] carrier;
  logic [CW-1:0] carrier_nx;
  logic [SW-1:0] car_ext;
  logic [SW-1:0] duty_eff;

  assign wrap = (carrier == CMAX);

  // next carrier value and the duty it will be compared against
  always_comb begin
    carrier_nx = '0;
    if (active_nx && !load && !wrap)
      carrier_nx = carrier + CW'(1);
    car_ext  = SW'(carrier_nx);
    duty_eff = SW'(sat(32'(duty_nx), 32'(pwm_period)));
  end

  // carrier and output register, aligned to the same cycle
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      carrier <= '0;
      PWM_out <= 1'b0;
    end else begin
      carrier <= carrier_nx;
      PWM_out <= active_nx && (car_ext < duty_eff);
    end
  end

endmodule

// File: rtl/pwm_table_player.sv
// pwm_table_player: sweeps the signal table and
// plays each sample as a PWM duty, with prefetch.
module pwm_table_player
  import pwm_pkg::*;
#(
  parameter int data_width         = 8,
  parameter int addr_width         = 7,
  parameter int data_range         = 100,
  parameter int pwm_period         = 100,
  parameter int periods_per_sample = 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Enable,
  output logic [addr_width-1:0] address,
  output logic                  WR,
  input  logic [data_width-1:0] sample_in,
  output logic                  PWM_out,
  output logic                  sample_strobe,
  output logic                  cycle_done,
  output logic [data_width-1:0] duty
);

  localparam int PW = cw(periods_per_sample);
  localparam logic [PW-1:0] PLAST =
    PW'(periods_per_sample - 1);
  localparam logic [addr_width-1:0] ALAST =
    addr_width'(data_range - 1);

  state_t                  state;
  state_t                  state_nx;
  logic [PW-1:0]           per_cnt;
  logic [data_width-1:0]   next_duty;
  logic [data_width-1:0]   duty_nx;
  logic [addr_width-1:0]   addr_step;
  logic [1:0]              pf;
  logic                    wrap;
  logic                    per_last;
  logic                    bnd_first;
  logic                    bnd_run;
  logic                    bnd;
  logic                    active_nx;

  assign WR = 1'b0;

  // next-state decode; Enable low forces IDLE
  always_comb begin
    state_nx = state;
    if (!Enable) begin
      state_nx = IDLE;
    end else begin
      unique case (1'b1)
        state == IDLE:   state_nx = PRIME0;
        state == PRIME0: state_nx = PRIME1;
        state == PRIME1: state_nx = RUN;
        state == RUN:    state_nx = RUN;
      endcase
    end
  end

  // sample boundaries, address step and duty selection
  always_comb begin
    per_last  = (per_cnt == PLAST);
    bnd_first = Enable && (state == PRIME1);
    bnd_run   = Enable && (state == RUN)
                && wrap && per_last;
    bnd       = bnd_first || bnd_run;
    active_nx = Enable
                && ((state == PRIME1) || (state == RUN));
    addr_step = (address == ALAST)
                ? '0 : address + addr_width'(1);
    duty_nx   = duty;
    if (bnd_first)
      duty_nx = sample_in;
    else if (bnd_run)
      duty_nx = next_duty;
  end

  // FSM state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // address sequencer, one step per sample boundary
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      address <= '0;
    else if (!Enable)
      address <= '0;
    else if (bnd)
      address <= addr_step;
  end

  // periods played of the current sample
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      per_cnt <= '0;
    else if (!active_nx || bnd)
      per_cnt <= '0;
    else if ((state == RUN) && wrap)
      per_cnt <= per_cnt + PW'(1);
  end

  // duty double buffer; prefetch lands two cycles after address moves
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      duty      <= '0;
      next_duty <= '0;
      pf        <= '0;
    end else if (!Enable) begin
      duty      <= '0;
      next_duty <= '0;
      pf        <= '0;
    end else begin
      pf <= {pf[0], bnd};
      if (bnd)
        duty <= duty_nx;
      if (bnd_first || pf[1])
        next_duty <= sample_in;
    end
  end

  // one-cycle pulses marking a new duty and a full table pass
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sample_strobe <= 1'b0;
      cycle_done    <= 1'b0;
    end else begin
      sample_strobe <= bnd;
      cycle_done    <= bnd_run && (address == '0);
    end
  end

  pwm_comparator #(
    .data_width (data_width),
    .pwm_period (pwm_period)
  ) u_cmp (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .active_nx (active_nx),
    .load      (bnd),
    .duty_nx   (duty_nx),
    .wrap      (wrap),
    .PWM_out   (PWM_out)
  );

endmodule

// File: tb/tb_pwm_table_player.sv
// tb_pwm_table_player: directed checks of playback,
// saturation, hold periods, wrap, disable and reset.
module tb_pwm_table_player;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic Enable = 1'b0;

  always #5 Clk = ~Clk;

  logic [6:0] a0, a1, a2, a3;
  logic [7:0] s0, s1, s2, s3;
  logic [7:0] d0, d1, d2, d3;
  logic wr0, wr1, wr2, wr3;
  logic p0, p1, p2, p3;
  logic st0, st1, st2, st3;
  logic cd0, cd1, cd2, cd3;

  logic [7:0] tab0 [0:127];
  logic [7:0] tab1 [0:127];
  logic [7:0] tab2 [0:127];
  logic [7:0] tab3 [0:127];

  always @(posedge Clk) begin
    s0 <= tab0[a0];
    s1 <= tab1[a1];
    s2 <= tab2[a2];
    s3 <= tab3[a3];
  end

  pwm_table_player #(
    .data_width(8), .addr_width(7), .data_range(3),
    .pwm_period(100), .periods_per_sample(1)
  ) u0 (
    .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable),
    .address(a0), .WR(wr0), .sample_in(s0),
    .PWM_out(p0), .sample_strobe(st0),
    .cycle_done(cd0), .duty(d0)
  );

  pwm_table_player #(
    .data_width(8), .addr_width(7), .data_range(4),
    .pwm_period(100), .periods_per_sample(1)
  ) u1 (
    .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable),
    .address(a1), .WR(wr1), .sample_in(s1),
    .PWM_out(p1), .sample_strobe(st1),
    .cycle_done(cd1), .duty(d1)
  );

  pwm_table_player #(
    .data_width(8), .addr_width(7), .data_range(3),
    .pwm_period(100), .periods_per_sample(3)
  ) u2 (
    .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable),
    .address(a2), .WR(wr2), .sample_in(s2),
    .PWM_out(p2), .sample_strobe(st2),
    .cycle_done(cd2), .duty(d2)
  );

  pwm_table_player #(
    .data_width(8), .addr_width(7), .data_range(100),
    .pwm_period(4), .periods_per_sample(1)
  ) u3 (
    .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable),
    .address(a3), .WR(wr3), .sample_in(s3),
    .PWM_out(p3), .sample_strobe(st3),
    .cycle_done(cd3), .duty(d3)
  );

  int tests = 0;
  int fails = 0;

  int exp0 [6] = '{25, 50, 75, 25, 50, 75};
  int exp1 [6] = '{0, 100, 100, 50, 0, 100};
  int hi0  [6];
  int hi1  [6];
  int hi2a, hi2b, st2n, st3n, cd0n, cd1n, cd3n;
  int gap_err, last3, wr_seen, p;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] want
  );
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d",
             tag, obs, want);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      tab0[i] = 8'd0;
      tab1[i] = 8'd0;
      tab2[i] = 8'd0;
      tab3[i] = 8'(i);
    end
    tab0[0] = 8'd25; tab0[1] = 8'd50; tab0[2] = 8'd75;
    tab1[0] = 8'd0;  tab1[1] = 8'd100;
    tab1[2] = 8'd200; tab1[3] = 8'd50;
    tab2[0] = 8'd25; tab2[1] = 8'd50; tab2[2] = 8'd75;
    for (int k = 0; k < 6; k++) begin
      hi0[k] = 0;
      hi1[k] = 0;
    end
    hi2a = 0; hi2b = 0; st2n = 0; st3n = 0;
    cd0n = 0; cd1n = 0; cd3n = 0;
    gap_err = 0; last3 = 0; wr_seen = 0;

    // reset state
    repeat (3) @(negedge Clk);
    chk("rst_addr", 32'(a0), 0);
    chk("rst_wr", 32'(wr0), 0);
    chk("rst_pwm", 32'(p0), 0);
    chk("rst_strobe", 32'(st0), 0);
    chk("rst_cdone", 32'(cd0), 0);
    chk("rst_duty", 32'(d0), 0);

    // release with Enable high: two priming cycles
    Rst_n = 1'b1;
    Enable = 1'b1;
    @(negedge Clk);
    chk("prime0_strobe", 32'(st0), 0);
    chk("prime0_pwm", 32'(p0), 0);
    @(negedge Clk);
    chk("prime1_strobe", 32'(st0), 0);
    chk("prime1_pwm", 32'(p0), 0);
    @(negedge Clk);
    chk("first_strobe", 32'(st0), 1);

    // 600 cycles of playback on all four instances
    for (int c = 0; c < 600; c++) begin
      p = c / 100;
      if (p0) hi0[p]++;
      if (p1) hi1[p]++;
      if (p2) begin
        if (c < 300) hi2a++;
        else hi2b++;
      end
      if (st2) st2n++;
      if (cd0) cd0n++;
      if (cd1) cd1n++;
      if (cd3) cd3n++;
      if (st3) begin
        st3n++;
        if (c != 0 && c - last3 != 4) gap_err++;
        last3 = c;
      end
      if (wr0 | wr1 | wr2 | wr3) wr_seen++;
      if (c == 0) begin
        chk("c0_duty", 32'(d0), 25);
        chk("c0_addr", 32'(a0), 1);
        chk("c0_sat0_pwm", 32'(p1), 0);
      end
      if (c == 100) begin
        chk("c100_strobe", 32'(st0), 1);
        chk("c100_duty", 32'(d0), 50);
        chk("c100_addr", 32'(a0), 2);
        chk("c100_hold_nostrobe", 32'(st2), 0);
      end
      if (c == 200) begin
        chk("c200_duty", 32'(d0), 75);
        chk("c200_addr", 32'(a0), 0);
        chk("c200_hold_addr", 32'(a2), 1);
      end
      if (c == 300) begin
        chk("c300_cdone", 32'(cd0), 1);
        chk("c300_duty", 32'(d0), 25);
        chk("c300_hold_strobe", 32'(st2), 1);
        chk("c300_hold_duty", 32'(d2), 50);
        chk("c300_hold_addr", 32'(a2), 2);
      end
      if (c == 396) begin
        chk("wrap_duty99", 32'(d3), 99);
        chk("wrap_addr0", 32'(a3), 0);
      end
      if (c == 400) begin
        chk("wrap_cdone", 32'(cd3), 1);
        chk("wrap_duty0", 32'(d3), 0);
        chk("wrap_addr1", 32'(a3), 1);
      end
      @(negedge Clk);
    end

    for (int k = 0; k < 6; k++) begin
      chk($sformatf("u0_high_p%0d", k), 32'(hi0[k]), 32'(exp0[k]));
      chk($sformatf("sat_high_p%0d", k), 32'(hi1[k]), 32'(exp1[k]));
    end
    chk("hold_high_a", 32'(hi2a), 75);
    chk("hold_high_b", 32'(hi2b), 150);
    chk("hold_strobes", 32'(st2n), 2);
    chk("u0_cdone_count", 32'(cd0n), 1);
    chk("sat_cdone_count", 32'(cd1n), 1);
    chk("wrap_strobes", 32'(st3n), 150);
    chk("wrap_gap_err", 32'(gap_err), 0);
    chk("wrap_cdone_count", 32'(cd3n), 1);
    chk("wr_seen", 32'(wr_seen), 0);

    // Enable drop at carrier 40 of a duty-75 period
    repeat (240) @(negedge Clk);
    chk("pre_drop_pwm", 32'(p0), 1);
    Enable = 1'b0;
    @(negedge Clk);
    chk("drop_pwm", 32'(p0), 0);
    chk("drop_addr", 32'(a0), 0);
    chk("drop_strobe", 32'(st0), 0);
    chk("drop_hold_addr", 32'(a2), 0);
    @(negedge Clk);
    Enable = 1'b1;
    @(negedge Clk);
    chk("re_p0_strobe", 32'(st0), 0);
    chk("re_p0_pwm", 32'(p0), 0);
    @(negedge Clk);
    chk("re_p1_strobe", 32'(st0), 0);
    chk("re_p1_pwm", 32'(p0), 0);
    @(negedge Clk);
    chk("re_strobe", 32'(st0), 1);
    chk("re_duty", 32'(d0), 25);
    chk("re_addr", 32'(a0), 1);
    chk("re_pwm", 32'(p0), 1);

    // asynchronous reset in the middle of a period
    repeat (10) @(negedge Clk);
    chk("pre_rst_pwm", 32'(p0), 1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_pwm", 32'(p0), 0);
    chk("arst_addr", 32'(a0), 0);
    chk("arst_duty", 32'(d0), 0);
    chk("arst_strobe", 32'(st0), 0);
    chk("arst_cdone", 32'(cd0), 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("rel_p0_strobe", 32'(st0), 0);
    @(negedge Clk);
    chk("rel_p1_strobe", 32'(st0), 0);
    @(negedge Clk);
    chk("rel_strobe", 32'(st0), 1);
    chk("rel_duty", 32'(d0), 25);
    chk("rel_hold_duty", 32'(d2), 25);
    chk("rel_sat_duty", 32'(d1), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
